// File: rtl/hex_entry_2digit_pkg.sv
// Shared types for the two-digit hex entry block: FSM states, button flag bundle,
// segment constants and the wrap-around nibble step used by the edit states.
package hex_entry_2digit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EDIT_HI = 2'd1,
    ST_EDIT_LO = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  typedef struct packed {
    logic enter;
    logic next;
    logic up;
    logic down;
  } flags_t;

  // Segments are active-low, bit order gfedcba.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Nibble arithmetic is mod 16 on its own: no carry or borrow leaks across.
  function automatic logic [3:0] nibble_step(input logic [3:0] nib, input logic up);
    return up ? nib + 4'd1 : nib - 4'd1;
  endfunction

endpackage

// File: rtl/hex_entry_2digit_if.sv
// Board-facing bundle of the hex entry block: four raw active-low buttons in,
// committed value, status and segment patterns out.
interface hex_entry_2digit_if;
  logic        button_enter;
  logic        button_next;
  logic        button_up;
  logic        button_down;
  logic [7:0]  value;
  logic        value_valid;
  logic        editing;
  logic        sel_hi;
  logic [13:0] digits;

  modport master (
    output button_enter, button_next, button_up, button_down,
    input  value, value_valid, editing, sel_hi, digits
  );

  modport slave (
    input  button_enter, button_next, button_up, button_down,
    output value, value_valid, editing, sel_hi, digits
  );
endinterface

// File: rtl/button_handler_down.sv
// Raw active-low button to a one-cycle press flag: two-flop synchronizer plus falling-edge detect.
// Flag rises three clocks after the button goes low; holding the button yields no further flags.
module button_handler_down (
  input  logic clock,
  input  logic reset,
  input  logic button_i,
  output logic press_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       press_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], button_i};
      prev_q  <= sync_q[1];
      press_q <= prev_q & ~sync_q[1];
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/hex22digit_hex.sv
// Hex nibble to active-low 7-segment pattern (gfedcba), lower-case b and d.
// Purely combinational.
module hex22digit_hex
  import hex_entry_2digit_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_entry_fsm.sv
// Edit/commit state machine holding the working and committed bytes and the idle timeout.
// All outputs registered; a flag acts on the next edge, value_valid pulses for the COMMIT cycle.
module hex_entry_fsm
  import hex_entry_2digit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  flags_t     flags_i,
  output logic [7:0] value_o,
  output logic       value_valid_o,
  output logic       editing_o,
  output logic       sel_hi_o,
  output logic [7:0] disp_o
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [7:0]      value_q;
  logic [7:0]      work_q;
  logic [7:0]      work_d;
  logic [TO_W-1:0] to_cnt_q;
  logic            valid_q;
  logic            editing_q;
  logic            sel_hi_q;
  logic            any_flag;

  assign any_flag = |flags_i;

  always_comb begin
    work_d = work_q;
    if (state_q == ST_EDIT_HI) work_d[7:4] = nibble_step(work_q[7:4], flags_i.up);
    else                       work_d[3:0] = nibble_step(work_q[3:0], flags_i.up);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      value_q   <= 8'h00;
      work_q    <= 8'h00;
      to_cnt_q  <= '0;
      valid_q   <= 1'b0;
      editing_q <= 1'b0;
      sel_hi_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          to_cnt_q <= '0;
          if (flags_i.enter) begin
            state_q   <= ST_EDIT_HI;
            work_q    <= value_q;
            editing_q <= 1'b1;
            sel_hi_q  <= 1'b1;
          end
        end
        ST_EDIT_HI, ST_EDIT_LO: begin
          to_cnt_q <= any_flag ? '0 : to_cnt_q + 1'b1;
          // enter > next > (up xor down); a flag always beats the timeout.
          if (flags_i.enter) begin
            state_q   <= ST_COMMIT;
            value_q   <= work_q;
            valid_q   <= 1'b1;
            editing_q <= 1'b0;
            sel_hi_q  <= 1'b0;
          end else if (flags_i.next) begin
            state_q  <= (state_q == ST_EDIT_HI) ? ST_EDIT_LO : ST_EDIT_HI;
            sel_hi_q <= (state_q == ST_EDIT_LO);
          end else if (flags_i.up ^ flags_i.down) begin
            work_q <= work_d;
          end else if (!any_flag && to_cnt_q == TO_LAST) begin
            state_q   <= ST_IDLE;
            to_cnt_q  <= '0;
            editing_q <= 1'b0;
            sel_hi_q  <= 1'b0;
          end
        end
        ST_COMMIT: begin
          state_q  <= ST_IDLE;
          to_cnt_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign value_o       = value_q;
  assign value_valid_o = valid_q;
  assign editing_o     = editing_q;
  assign sel_hi_o      = sel_hi_q;
  assign disp_o        = editing_q ? work_q : value_q;

endmodule

// File: rtl/hex_entry_2digit.sv
// Two-digit hex entry from four push-buttons, shown on two 7-segment digits; optional BLINK_EN blinks the selected digit.
// Button to state change is four clocks; digits follow one clock later; no backpressure on value_valid.
module hex_entry_2digit
  import hex_entry_2digit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
`ifdef BLINK_EN
  , parameter int unsigned BLINK_HALF = 12_500_000
`endif
) (
  input  logic              clock,
  input  logic              reset,
  hex_entry_2digit_if.slave bus
);

  logic        flag_enter, flag_next, flag_up, flag_down;
  flags_t      flags;
  logic [7:0]  disp;
  logic        editing;
  logic        sel_hi;
  logic [6:0]  seg_hi, seg_lo, seg_hi_show, seg_lo_show;
  logic [13:0] digits_q;

  button_handler_down u_btn_enter (.clock(clock), .reset(reset), .button_i(bus.button_enter), .press_o(flag_enter));
  button_handler_down u_btn_next  (.clock(clock), .reset(reset), .button_i(bus.button_next),  .press_o(flag_next));
  button_handler_down u_btn_up    (.clock(clock), .reset(reset), .button_i(bus.button_up),    .press_o(flag_up));
  button_handler_down u_btn_down  (.clock(clock), .reset(reset), .button_i(bus.button_down),  .press_o(flag_down));

  assign flags = {flag_enter, flag_next, flag_up, flag_down};

  hex_entry_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .clock        (clock),
    .reset        (reset),
    .flags_i      (flags),
    .value_o      (bus.value),
    .value_valid_o(bus.value_valid),
    .editing_o    (editing),
    .sel_hi_o     (sel_hi),
    .disp_o       (disp)
  );

  hex22digit_hex u_seg_lo (.nibble_i(disp[3:0]), .seg_o(seg_lo));
  hex22digit_hex u_seg_hi (.nibble_i(disp[7:4]), .seg_o(seg_hi));

`ifdef BLINK_EN
  localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  logic [BL_W-1:0] blink_cnt_q;
  logic            blink_off_q;
  logic            any_flag;

  assign any_flag = |flags;

  // Any press restarts the phase so the digit being edited is immediately visible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (!editing || any_flag) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
      blink_cnt_q <= '0;
      blink_off_q <= ~blink_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign seg_hi_show = (blink_off_q && editing && sel_hi)  ? SEG_BLANK : seg_hi;
  assign seg_lo_show = (blink_off_q && editing && !sel_hi) ? SEG_BLANK : seg_lo;
`else
  assign seg_hi_show = seg_hi;
  assign seg_lo_show = seg_lo;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) digits_q <= {SEG_ZERO, SEG_ZERO};
    else        digits_q <= {seg_hi_show, seg_lo_show};
  end

  assign bus.editing = editing;
  assign bus.sel_hi  = sel_hi;
  assign bus.digits  = digits_q;

endmodule
